// File: rtl/lcd_ctrl.sv
// HD44780 command engine: turns each toggle of the LCD register's request bit into one
// timed RS/DATA setup, EN pulse, hold and execution wait, with busy/overrun status.
module lcd_ctrl #(
    parameter int unsigned T_POWERUP   = 2000000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_EN        = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_lcd,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic [31:0] o_status
);

    // state   | meaning
    // POWERUP | post-reset LCD power-on wait, requests dropped
    // IDLE    | waiting for a request toggle
    // SETUP   | RS/DATA settling before EN rises
    // EN_HI   | EN strobe high
    // HOLD    | RS/DATA held after EN falls
    // EXEC    | LCD executing the command (short or long wait)
    typedef enum logic [2:0] {
        S_POWERUP, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_EXEC
    } state_t;

    localparam int unsigned MAX_A = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
    localparam int unsigned MAX_B = (T_EXEC > T_EN) ? T_EXEC : T_EN;
    localparam int unsigned MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int unsigned MAX_D = (MAX_B > MAX_C) ? MAX_B : MAX_C;
    localparam int unsigned MAX_T = (MAX_A > MAX_D) ? MAX_A : MAX_D;
    localparam int unsigned CW    = $clog2(MAX_T + 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            tog_q, req, accept, drop, last;
    logic            is_long_q, overrun_q, en_q, on_q, rs_q, busy;
    logic [7:0]      data_q;
    logic            unused_bits;

    assign unused_bits = ^{i_io_lcd[28:10], i_io_lcd[8]};

    assign req    = i_io_lcd[30] ^ tog_q;
    assign accept = req && (state == S_IDLE);
    assign drop   = req && (state != S_IDLE);
    assign last   = (cnt == CW'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_POWERUP;
            cnt   <= CW'(T_POWERUP);
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = (state == S_IDLE) ? cnt : cnt - CW'(1);
        case (state)
            S_POWERUP: if (last) state_nx = S_IDLE;
            S_IDLE: begin
                if (accept) begin
                    state_nx = S_SETUP;
                    cnt_nx   = CW'(T_SETUP);
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_nx = S_EN_HI;
                    cnt_nx   = CW'(T_EN);
                end
            end
            S_EN_HI: begin
                if (last) begin
                    state_nx = S_HOLD;
                    cnt_nx   = CW'(T_HOLD);
                end
            end
            S_HOLD: begin
                if (last) begin
                    state_nx = S_EXEC;
                    cnt_nx   = is_long_q ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
                end
            end
            S_EXEC: if (last) state_nx = S_IDLE;
            default: begin
                state_nx = S_POWERUP;
                cnt_nx   = CW'(T_POWERUP);
            end
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        o_status   = {30'b0, overrun_q, busy};
        o_lcd_en   = en_q;
        o_lcd_on   = on_q;
        o_lcd_rs   = rs_q;
        o_lcd_data = data_q;
        o_lcd_rw   = 1'b0;
    end

    // EN is flopped from the next state so the strobe itself never glitches on the pin
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tog_q     <= i_io_lcd[30];
            on_q      <= 1'b0;
            en_q      <= 1'b0;
            data_q    <= 8'h00;
            rs_q      <= 1'b0;
            is_long_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tog_q <= i_io_lcd[30];
            on_q  <= i_io_lcd[31];
            en_q  <= (state_nx == S_EN_HI);
            if (accept) begin
                data_q    <= i_io_lcd[7:0];
                rs_q      <= i_io_lcd[9];
                is_long_q <= !i_io_lcd[9] && (i_io_lcd[7:0] == 8'h01 ||
                             i_io_lcd[7:0] == 8'h02 || i_io_lcd[7:0] == 8'h03);
            end
            if (drop)
                overrun_q <= 1'b1;
            else if (i_io_lcd[29])
                overrun_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: requests push expected transactions, a monitor measures each busy
// period (EN offset/width, busy length, latched data) and pops/compares on busy fall.
module tb_lcd_ctrl;
    localparam int T_POWERUP = 10, T_SETUP = 2, T_EN = 3, T_HOLD = 2, T_EXEC = 5, T_EXEC_LONG = 20;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_io_lcd;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
    logic [31:0] o_status;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         busy_len;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   bc = 0, ec = 0, eo = 0, np = 0;
    logic pb = 1'b1, pe = 1'b0;

    lcd_ctrl #(
        .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_io_lcd(i_io_lcd),
        .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_status(o_status)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // monitor: one record per busy period, closed when busy falls
    always @(posedge i_clk) begin
        exp_t e;
        #1;
        if (i_reset) begin
            bc = 0; ec = 0; eo = 0; np = 0; pb = 1'b1; pe = 1'b0;
        end else begin
            if (o_lcd_en && !pe) begin
                np++;
                eo = bc;
            end
            if (o_lcd_en) ec++;
            if (o_status[0]) bc++;
            if (!o_status[0] && pb) begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("data", o_lcd_data, e.data);
                    chk("rs", o_lcd_rs, e.rs);
                    chk("busy_len", bc, e.busy_len);
                    chk("en_pulses", np, 1);
                    chk("en_offset", eo, T_SETUP);
                    chk("en_width", ec, T_EN);
                end else begin
                    chk("stray_en", np, 0);
                end
                bc = 0; ec = 0; eo = 0; np = 0;
            end
            pb = o_status[0];
            pe = o_lcd_en;
        end
    end

    task automatic send(input logic rs, input logic [7:0] b);
        exp_t e;
        i_io_lcd[9]   = rs;
        i_io_lcd[7:0] = b;
        i_io_lcd[30]  = ~i_io_lcd[30];
        e.data     = b;
        e.rs       = rs;
        e.busy_len = T_SETUP + T_EN + T_HOLD +
                     ((!rs && b >= 8'h01 && b <= 8'h03) ? T_EXEC_LONG : T_EXEC);
        sb_q.push_back(e);
        @(negedge i_clk);
    endtask

    task automatic drop_toggle();
        i_io_lcd[7:0] = 8'hEE;
        i_io_lcd[30]  = ~i_io_lcd[30];
        @(negedge i_clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_status[0] && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (o_status[0]) chk("idle_timeout", o_status[0], 0);
    endtask

    // called on the negedge where reset is released
    task automatic pwr_count(input int drop_at);
        int n = 0;
        while (o_status[0] && n < 100) begin
            if (o_lcd_en) chk("pwr_en", o_lcd_en, 0);
            if (n == drop_at) i_io_lcd[30] = ~i_io_lcd[30];
            n++;
            @(negedge i_clk);
        end
        chk("pwr_len", n, T_POWERUP);
        chk("pwr_data", o_lcd_data, 0);
        chk("pwr_rs", o_lcd_rs, 0);
        chk("pwr_rw", o_lcd_rw, 0);
    endtask

    initial begin
        i_reset  = 1'b1;
        i_io_lcd = 32'h0;
        repeat (3) @(negedge i_clk);
        chk("rst_busy", o_status[0], 1);
        chk("rst_ovr", o_status[1], 0);
        chk("rst_en", o_lcd_en, 0);
        chk("rst_data", o_lcd_data, 0);
        chk("rst_on", o_lcd_on, 0);
        chk("rst_status_hi", int'(o_status[31:2]), 0);
        i_reset = 1'b0;
        pwr_count(-1);

        i_io_lcd[31] = 1'b1;
        @(negedge i_clk);
        chk("lcd_on", o_lcd_on, 1);

        send(1'b1, 8'h41);
        chk("data_after_a", o_lcd_data, 8'h41);
        chk("rs_after_a", o_lcd_rs, 1);
        chk("busy_after_a", o_status[0], 1);
        wait_idle(); @(negedge i_clk);

        send(1'b0, 8'h01); wait_idle(); @(negedge i_clk);
        send(1'b0, 8'h38); wait_idle(); @(negedge i_clk);
        send(1'b0, 8'h03); wait_idle(); @(negedge i_clk);
        send(1'b1, 8'h01); wait_idle(); @(negedge i_clk);
        send(1'b0, 8'h04); wait_idle(); @(negedge i_clk);
        chk("no_ovr_yet", o_status[1], 0);

        // second toggle sampled 4 cycles after acceptance
        send(1'b1, 8'h5A);
        repeat (3) @(negedge i_clk);
        drop_toggle();
        wait_idle(); @(negedge i_clk);
        chk("ovr_set", o_status[1], 1);
        chk("ovr_data_kept", o_lcd_data, 8'h5A);
        i_io_lcd[29] = 1'b1;
        @(negedge i_clk);
        i_io_lcd[29] = 1'b0;
        chk("ovr_clear", o_status[1], 0);

        // back-to-back: toggle sampled on the first edge with busy low
        send(1'b1, 8'h61);
        wait_idle();
        send(1'b1, 8'h62);
        wait_idle(); @(negedge i_clk);
        chk("b2b_no_ovr", o_status[1], 0);

        // reset while EN is high, with overrun set beforehand
        send(1'b1, 8'h77);
        drop_toggle();
        begin
            int n = 0;
            while (!o_lcd_en && n < 20) begin
                @(negedge i_clk);
                n++;
            end
            chk("en_reached", o_lcd_en, 1);
        end
        chk("ovr_before_rst", o_status[1], 1);
        i_reset = 1'b1;
        sb_q.delete();
        @(negedge i_clk);
        chk("rst_en_low", o_lcd_en, 0);
        chk("rst_busy2", o_status[0], 1);
        chk("rst_ovr2", o_status[1], 0);
        chk("rst_data2", o_lcd_data, 0);
        i_reset = 1'b0;
        pwr_count(3);
        chk("pwr_drop_ovr", o_status[1], 1);
        i_io_lcd[29] = 1'b1;
        @(negedge i_clk);
        i_io_lcd[29] = 1'b0;
        chk("pwr_ovr_clear", o_status[1], 0);

        send(1'b0, 8'h02); wait_idle();
        repeat (3) @(negedge i_clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

HD44780 character-LCD command engine sitting behind the LSU's memory-mapped LCD register (the `o_io_lcd` word at 0x1000_4xxx). Software writes one command or data byte per request into that register. This block detects each new request, sequences the LCD bus (RS/RW/DATA setup, EN pulse, hold, execution wait) and exposes a busy/overrun status word, which the top level routes back to a read-only LSU address. Software never bit-bangs EN.

## Interface
Parameters (all in `i_clk` cycles, each ≥1):
- `T_POWERUP`, 2000000: post-reset LCD power-on wait (40 ms at 50 MHz).
- `T_SETUP`, 2: RS/DATA stable before EN rises.
- `T_EN`, 12: EN high width.
- `T_HOLD`, 2: RS/DATA stable after EN falls.
- `T_EXEC`, 2000: execution wait for normal commands and data.
- `T_EXEC_LONG`, 82000: execution wait for clear and home.

Ports:
- `i_clk` in 1: the single clock.
- `i_reset` in 1: reset. **Synchronous, active-high.**
- `i_io_lcd` in 32: LCD register. Field map:
  - [31] LCD on.
  - [30] request toggle.
  - [29] overrun clear (level).
  - [9] RS.
  - [7:0] byte.
  - All other bits ignored.
- `o_lcd_data` out 8: LCD DB[7:0].
- `o_lcd_rs` out 1: register select.
- `o_lcd_rw` out 1: read/write, constant 0 (write-only).
- `o_lcd_en` out 1: enable strobe.
- `o_lcd_on` out 1: LCD power, registered copy of `i_io_lcd[31]`.
- `o_status` out 32: {30'b0, overrun, busy}.

## Operation
- States: POWERUP, IDLE, SETUP, EN_HI, HOLD, EXEC. One down-counter, sized for the largest parameter.
- Request detection:
  - Register `tog_q` tracks `i_io_lcd[30]`.
  - A request occurs on any edge where `i_io_lcd[30] != tog_q`.
  - `tog_q` updates every edge.
- POWERUP:
  - Entered on reset.
  - Counts `T_POWERUP` cycles, then goes to IDLE.
- IDLE + request:
  - Latch `i_io_lcd[7:0]` and [9] into the data/RS outputs.
  - Classify the request as long if RS=0 and byte ∈ {0x01, 0x02, 0x03}; otherwise short.
  - Go to SETUP.
- SETUP: `T_SETUP` cycles, then EN_HI.
- EN_HI: `o_lcd_en`=1 for `T_EN` cycles, then HOLD.
- HOLD: `T_HOLD` cycles, then EXEC.
- EXEC: `T_EXEC` cycles, or `T_EXEC_LONG` for long requests, then IDLE.
- busy = (state != IDLE).
- Request while busy (including POWERUP):
  - The request is dropped; there is no queue.
  - overrun is set (sticky).
  - `tog_q` still updates, so one toggle produces exactly one request or one drop.
- overrun is cleared on any edge where `i_io_lcd[29]`=1. If a drop occurs on the same edge, set wins.
- `o_lcd_data` and `o_lcd_rs` change only on request acceptance and hold their value indefinitely afterwards.

## Timing
- Reset values, applied on the edge where `i_reset`=1:
  - state=POWERUP, counter=`T_POWERUP`.
  - `o_lcd_en`=0, `o_lcd_data`=0, `o_lcd_rs`=0, `o_lcd_rw`=0, `o_lcd_on`=0.
  - busy=1, overrun=0.
  - `tog_q` ← `i_io_lcd[30]`, so there is no spurious request after reset.
- Reset mid-operation: any state, including EN_HI, returns to POWERUP with EN low on that same edge. The pending command is abandoned.
- Acceptance edge A (request sampled in IDLE):
  - data/RS/busy visible after A.
  - EN rises after edge A+`T_SETUP`.
  - EN falls after A+`T_SETUP`+`T_EN`.
  - busy falls after A+`T_SETUP`+`T_EN`+`T_HOLD`+T_exec.
- First request acceptable on the edge after busy falls. A toggle on that edge is accepted, not dropped.
- All outputs are registered; there are no combinational input-to-output paths.
- `o_lcd_on` is `i_io_lcd[31]` delayed one cycle. It is independent of state.
- Toggle reversals across consecutive cycles count as separate requests.

## Test plan
All scenarios use `T_POWERUP`=10, `T_SETUP`=2, `T_EN`=3, `T_HOLD`=2, `T_EXEC`=5, `T_EXEC_LONG`=20.

- **Reset/power-up.** Assert reset 3 cycles, release.
  - Required: busy=1 for exactly 10 cycles, then 0.
  - All LCD outputs 0 throughout; no EN pulse.
- **Data write.** Toggle [30] with RS=1, byte 0x41.
  - Required: data=0x41, rs=1 after A.
  - EN high exactly 3 cycles starting after A+2.
  - busy high for 12 cycles total.
- **Long command.** Toggle with RS=0, byte 0x01.
  - Required: busy high for 27 cycles.
  - Repeat with byte 0x38: busy high 12 cycles.
- **Overrun.** Issue a second toggle 4 cycles after A.
  - Required: only one EN pulse; overrun=1 stays set after busy falls.
  - Assert [29] for 1 cycle: overrun returns to 0.
  - A toggle during POWERUP also sets overrun.
- **Back-to-back.** Toggle on the exact edge busy falls.
  - Required: accepted, no overrun; the second EN pulse starts 2 cycles after acceptance.
- **Reset during EN_HI.**
  - Required: EN=0 after the reset edge, busy=1, POWERUP count restarts at 10, overrun=0.
